// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle RV32I fetch/decode/exec/mem/wb sequencer
// Optional memory wait timeout with HALT state: define SEQ_MEM_TIMEOUT_EN.
module mc_sequencer #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             ir_we,
   input  logic             memtoreg,
   input  logic             memwr,
   input  logic             regwr,
   input  logic [2:0]       branch,
   input  logic             take_branch,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             rf_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic [2:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] instret,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             wait_expired;

`ifdef SEQ_MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wait_cnt;
   logic          waiting;

   // Leaving FETCH/MEM or seeing the ack clears the count, so every entry starts at zero.
   assign waiting = ((state_q == S_FETCH) && !imem_ack) ||
                    ((state_q == S_MEM) && !dmem_ack);

   always_ff @(posedge clk) begin
      if (rst || !waiting) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign wait_expired = waiting && ((32'(wait_cnt) + 32'd1) == 32'(TIMEOUT));
   assign err          = (state_q == S_HALT);
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT != 0);
   assign wait_expired   = 1'b0;
   assign err            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= '0;
      end else if (state_q == S_WB) begin
         instret_q <= instret_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_HALT;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            state_d = (memtoreg || memwr) ? S_MEM : S_WB;
         end
         S_MEM: begin
            // memtoreg+memwr together resolves to a store
            dmem_req = 1'b1;
            dmem_we  = memwr;
            if (dmem_ack) begin
               state_d = S_WB;
            end else if (wait_expired) begin
               state_d = S_HALT;
            end
         end
         S_WB: begin
            rf_we   = regwr;
            pc_we   = 1'b1;
            pc_sel  = (branch == 3'b001) || (branch == 3'b010) ||
                      (branch[2] && take_branch);
            state_d = run ? S_FETCH : S_IDLE;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   assign state   = state_q;
   assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
   assign instret = instret_q;

endmodule
